// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
//   flush        master->slave  kill the op in flight
//   req_valid    master->slave  request present
//   req_ready    slave->master  unit can accept this cycle
//   req_op       master->slave  funct3 (0 MUL .. 7 REMU)
//   req_op1/2    master->slave  rs1 / rs2 values
//   resp_valid   slave->master  result valid, held until resp_ready
//   resp_ready   master->slave  consumer takes the result
//   resp_result  slave->master  registered result
//   busy         slave->master  unit not idle
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_op1;
    logic [XLEN-1:0] req_op2;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;
    logic            busy;

    modport master (
        output flush, req_valid, req_op, req_op1, req_op2, resp_ready,
        input  req_ready, resp_valid, resp_result, busy
    );

    modport slave (
        input  flush, req_valid, req_op, req_op1, req_op2, resp_ready,
        output req_ready, resp_valid, resp_result, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit sitting beside the ALU in EX.
// Multiplies finish after a fixed latency; divides run a 1-bit/cycle restoring
// iteration on magnitudes followed by a sign fix-up cycle. Divide-by-zero and
// signed overflow are resolved at accept and complete in one cycle.
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   bus          muldiv_if.slave: request/response handshake, flush, busy
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request
// MUL    | product settling, counter runs MUL_LATENCY-1 cycles
// DIV    | restoring iterations on operand magnitudes, XLEN cycles
// FIX    | apply quotient/remainder signs
// DONE   | resp_valid high, result held until resp_ready
module muldiv_unit #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    muldiv_if.slave   bus
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    localparam int CNT_W = 8;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, state_nxt, entry_state;
    logic            req_ready, accept;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q, rem_q, res_q;
    logic            quo_neg, rem_neg;
    logic [CNT_W-1:0] cnt;

    // Incoming request decode
    logic            in_signed, in_neg1, in_neg2, op2_zero, ovf, special;
    logic [XLEN-1:0] mag1, mag2, special_res;

    assign in_signed = !bus.req_op[0];
    assign in_neg1   = in_signed & bus.req_op1[XLEN-1];
    assign in_neg2   = in_signed & bus.req_op2[XLEN-1];
    assign mag1      = in_neg1 ? -bus.req_op1 : bus.req_op1;
    assign mag2      = in_neg2 ? -bus.req_op2 : bus.req_op2;
    assign op2_zero  = (bus.req_op2 == '0);
    assign ovf       = in_signed && (bus.req_op1 == MIN_NEG) && (&bus.req_op2);
    assign special   = bus.req_op[2] & (op2_zero | ovf);
    // Division by zero wins over overflow (op2 cannot be both zero and all ones).
    assign special_res = op2_zero ? (bus.req_op[1] ? bus.req_op1 : '1)
                                  : (bus.req_op[1] ? '0 : bus.req_op1);

    // Multiply: sign-extending both operands to 2*XLEN makes the low 2*XLEN
    // bits of a plain product correct for signed, mixed and unsigned forms.
    logic              a_sx, b_sx;
    logic [2*XLEN-1:0] a_w, b_w, prod;
    logic [XLEN-1:0]   mul_res;

    assign a_sx    = ((op_q == 3'd1) || (op_q == 3'd2)) & a_q[XLEN-1];
    assign b_sx    = (op_q == 3'd1) & b_q[XLEN-1];
    assign a_w     = {{XLEN{a_sx}}, a_q};
    assign b_w     = {{XLEN{b_sx}}, b_q};
    assign prod    = a_w * b_w;
    assign mul_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // Divide step: a_q shifts the dividend out at the top and collects quotient bits.
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] fix_res;

    assign rem_sh  = {rem_q, a_q[XLEN-1]};
    assign diff    = rem_sh - {1'b0, b_q};
    assign fix_res = op_q[1] ? (rem_neg ? -rem_q : rem_q)
                             : (quo_neg ? -a_q : a_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state
    always_comb begin
        entry_state = !bus.req_op[2] ? S_MUL : (special ? S_DONE : S_DIV);
        state_nxt   = state;
        case (state)
            S_IDLE: if (accept) state_nxt = entry_state;
            S_MUL:  if (cnt <= CNT_W'(1)) state_nxt = S_DONE;
            S_DIV:  if (cnt == '0) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_DONE: begin
                if (accept)              state_nxt = entry_state;
                else if (bus.resp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (bus.flush) state_nxt = S_IDLE;
    end

    // Outputs
    always_comb begin
        req_ready      = !bus.flush && ((state == S_IDLE) || ((state == S_DONE) && bus.resp_ready));
        accept         = bus.req_valid && req_ready;
        bus.req_ready  = req_ready;
        bus.resp_valid = (state == S_DONE);
        bus.busy       = (state != S_IDLE);
    end

    assign bus.resp_result = res_q;

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            res_q   <= '0;
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
            cnt     <= '0;
        end else if (bus.flush) begin
            cnt <= '0;
        end else if (accept) begin
            op_q  <= bus.req_op;
            rem_q <= '0;
            cnt   <= bus.req_op[2] ? CNT_W'(XLEN-1) : CNT_W'(MUL_LATENCY-1);
            if (bus.req_op[2]) begin
                a_q     <= mag1;
                b_q     <= mag2;
                quo_neg <= in_neg1 ^ in_neg2;
                rem_neg <= in_neg1;
            end else begin
                a_q <= bus.req_op1;
                b_q <= bus.req_op2;
            end
            if (special) res_q <= special_res;
        end else begin
            case (state)
                S_MUL: begin
                    if (cnt <= CNT_W'(1)) res_q <= mul_res;
                    else                  cnt   <= cnt - 1'b1;
                end
                S_DIV: begin
                    if (!diff[XLEN]) begin
                        rem_q <= diff[XLEN-1:0];
                        a_q   <= {a_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_q <= rem_sh[XLEN-1:0];
                        a_q   <= {a_q[XLEN-2:0], 1'b0};
                    end
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                S_FIX:   res_q <= fix_res;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    localparam int XLEN        = 32;
    localparam int MUL_LATENCY = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    muldiv_if #(.XLEN(XLEN)) bus ();
    muldiv_unit #(.XLEN(XLEN), .MUL_LATENCY(MUL_LATENCY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          cyc;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int x, y;
        x = $signed(a);
        y = $signed(b);
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = longint'(x) * longint'(y); return p[63:32]; end
            3'd2: begin p = longint'(x) * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: if (b == 0) return 32'hFFFF_FFFF;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                  else return x / y;
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: if (b == 0) return a;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                  else return x % y;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return MUL_LATENCY;
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 2;
    endfunction

    // Presents a request and returns one #1 after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        int guard = 0;
        bus.req_op    = op;
        bus.req_op1   = a;
        bus.req_op2   = b;
        bus.req_valid = 1'b1;
        #1;
        while (!bus.req_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.req_ready) timeout_fail("issue_ready");
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        sb.push_back(exp);
    endtask

    // Counts cycles since accept (first sample after the accept edge is cycle 1).
    task automatic wait_resp(input int start, input int exp_cyc, input string name);
        int cyc = start;
        logic [31:0] exp;
        while (!bus.resp_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!bus.resp_valid) begin
            timeout_fail(name);
            return;
        end
        if (sb.size() == 0) begin
            timeout_fail({name, "_sb_empty"});
            return;
        end
        exp = sb.pop_front();
        chk(name, bus.resp_result, exp);
        chk({name, "_lat"}, cyc, exp_cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          seen;

        vecs.push_back('{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 2,  "mul_7_m3"});
        vecs.push_back('{3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2,  "mulh"});
        vecs.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2,  "mulhsu"});
        vecs.push_back('{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 2,  "mulhu"});
        vecs.push_back('{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2,  "mul_m1_m1"});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2,  "mulhu_max"});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, "div_m7_2"});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, "rem_m7_2"});
        vecs.push_back('{3'd5, 32'd100,       32'd7,         32'd14,        34, "divu_100_7"});
        vecs.push_back('{3'd7, 32'd100,       32'd7,         32'd2,         34, "remu_100_7"});
        vecs.push_back('{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div_7_m2"});
        vecs.push_back('{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         34, "rem_7_m2"});
        vecs.push_back('{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  "div_by0"});
        vecs.push_back('{3'd6, 32'd5,         32'd0,         32'd5,         1,  "rem_by0"});
        vecs.push_back('{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  "divu_by0"});
        vecs.push_back('{3'd7, 32'd9,         32'd0,         32'd9,         1,  "remu_by0"});
        vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf"});
        vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  "rem_ovf"});
        vecs.push_back('{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34, "divu_noovf"});
        vecs.push_back('{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "remu_noovf"});

        bus.flush      = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = '0;
        bus.req_op1    = '0;
        bus.req_op2    = '0;
        bus.resp_ready = 1'b1;
        rst_n          = 1'b0;

        #2;
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_result", bus.resp_result, 0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_req_ready", bus.req_ready, 1);

        // Table vectors, issued back-to-back with the previous response
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
            wait_resp(1, vecs[i].cyc, vecs[i].name);
        end

        // Random ops against the reference model
        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            issue(rop, ra, rb, model(rop, ra, rb));
            wait_resp(1, lat_of(rop, ra, rb), "rand");
        end

        // Result held while resp_ready is low, then back-to-back accept
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        issue(3'd5, 32'd100, 32'd7, 32'd14);
        wait_resp(1, 34, "hold_divu");
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (!bus.resp_valid || bus.resp_result !== 32'd14) seen++;
        end
        chk("hold_stable", seen, 0);
        bus.resp_ready = 1'b1;
        #1;
        chk("hold_release_ready", bus.req_ready, 1);
        issue(3'd0, 32'd3, 32'd4, 32'd12);
        chk("b2b_resp_cleared", bus.resp_valid, 0);
        chk("b2b_busy", bus.busy, 1);
        wait_resp(1, 2, "b2b_mul");

        // Requests while busy are ignored
        @(posedge clk); #1;
        issue(3'd5, 32'd100, 32'd7, 32'd14);
        bus.req_op    = 3'd0;
        bus.req_op1   = 32'd9;
        bus.req_op2   = 32'd9;
        bus.req_valid = 1'b1;
        seen = 0;
        repeat (5) begin
            if (bus.req_ready) seen++;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        chk("busy_no_ready", seen, 0);
        wait_resp(6, 34, "busy_divu");

        // Flush in the middle of a divide
        @(posedge clk); #1;
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        repeat (9) begin
            @(posedge clk); #1;
        end
        bus.flush = 1'b1;
        #1;
        chk("flush_ready_low", bus.req_ready, 0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_idle_busy", bus.busy, 0);
        chk("flush_no_valid", bus.resp_valid, 0);
        void'(sb.pop_back());
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.resp_valid || bus.busy) seen++;
        end
        chk("flush_quiet", seen, 0);
        issue(3'd0, 32'd3, 32'd4, 32'd12);
        wait_resp(1, 2, "flush_next_mul");

        // Asynchronous reset mid-divide
        @(posedge clk); #1;
        issue(3'd5, 32'd100, 32'd7, 32'd14);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_valid", bus.resp_valid, 0);
        chk("arst_result", bus.resp_result, 0);
        sb.delete();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_ready", bus.req_ready, 1);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        wait_resp(1, 2, "arst_next_mulh");

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
